mem_ctrl: RTL

Arbitrates the single byte-wide RAM port between instruction fetch (IF) and load/store (MEM). Each granted access is sequenced as a multi-cycle byte transfer, and a 32-bit word is assembled little-endian. The block also produces the stall requests that `ctrl` turns into the `stall` bus, which freezes or bubbles the pipeline registers (pc_reg, if_id, id_ex, ex_mem) while an access is outstanding.

---
 rtl/mem_ctrl_pkg.sv | 39 +++
 rtl/mem_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_pkg
//  Description : Shared types and constants for the byte-wide RAM port
//                controller: access-length codes, FSM state encoding,
//                RAM byte type and a helper that maps a length code to a
//                byte count.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

  // Access length codes carried on mem_len.
  typedef logic [1:0] mem_len_t;
  localparam mem_len_t MEM_LEN_B = 2'd0;
  localparam mem_len_t MEM_LEN_H = 2'd1;
  localparam mem_len_t MEM_LEN_W = 2'd2;

  // Controller state encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_RD  = 2'd1,
    ST_MEM_RD = 2'd2,
    ST_MEM_WR = 2'd3
  } mem_state_t;

  // One RAM byte.
  typedef logic [7:0] ram_byte_t;

  // Byte count for a length code; the unused code 3 behaves as a word.
  function automatic logic [2:0] len_to_n(input mem_len_t len);
    case (len)
      MEM_LEN_B: len_to_n = 3'd1;
      MEM_LEN_H: len_to_n = 3'd2;
      default:   len_to_n = 3'd4;
    endcase
  endfunction

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl
//  Description : Arbitrates one byte-wide RAM port between instruction fetch
//                (IF) and load/store (MEM). Each granted access is run as a
//                sequence of single-byte transfers; read words are assembled
//                little-endian. Also produces the pipeline stall requests.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst                 clock, synchronous active-low reset
//    if_req/if_addr/flush     IF fetch request, byte address, branch flush
//    mem_req/mem_we/mem_addr/
//    mem_len/mem_wdata        MEM load/store request
//    if_done/if_data          fetch completion pulse and instruction word
//    mem_done/mem_rdata       load/store completion pulse and load data
//    stallreq_if/stallreq_mem stall requests to the pipeline controller
//    ram_din                  RAM read byte (1-cycle read latency)
//    ram_a/ram_dout/ram_wr    RAM address, write byte, write strobe
// ============================================================================
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_wdata,
  output logic              if_done,
  output logic [31:0]       if_data,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              stallreq_if,
  output logic              stallreq_mem,
  input  logic [7:0]        ram_din,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr
);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  mem_state_t        r_state;
  mem_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [2:0]        r_cnt;
  logic [2:0]        r_n;
  logic [31:0]       r_wdata;
  logic [31:0]       r_asm;
  logic [31:0]       r_if_data;
  logic [31:0]       r_mem_rdata;
  logic              r_if_done;
  logic              r_mem_done;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic              w_idle_ok;
  logic              w_grant_mem;
  logic              w_grant_if;
  logic              w_last_rd;
  logic              w_last_wr;
  logic              w_in_range;
  logic              w_if_fin;
  logic              w_mem_fin;
  logic              w_rd_state;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_lane;
  logic [31:0]       w_asm_nxt;
  ram_byte_t         w_wr_byte;

  // A done pulse in flight blocks any new grant for that cycle, so the
  // requester that just completed gets one bubble to drop its level request.
  assign w_idle_ok   = (r_state == ST_IDLE) & ~r_if_done & ~r_mem_done;
  assign w_grant_mem = w_idle_ok & mem_req;
  assign w_grant_if  = w_idle_ok & ~mem_req & if_req & ~flush;

  assign w_last_rd   = (r_cnt == r_n);
  assign w_last_wr   = (r_cnt == (r_n - 3'd1));
  assign w_in_range  = (r_cnt < r_n);
  assign w_rd_state  = (r_state == ST_IF_RD) | (r_state == ST_MEM_RD);

  // Wraps naturally modulo 2^ADDR_W.
  assign w_addr      = r_base + ADDR_W'(r_cnt);

  // RAM data returns one cycle after its address, so the byte arriving
  // while cnt == k belongs to lane k-1. cnt == 4 maps to lane 3 by wrapping.
  assign w_lane      = r_cnt[1:0] - 2'd1;
  assign w_wr_byte   = r_wdata[{r_cnt[1:0], 3'b000} +: 8];

  always_comb begin
    w_asm_nxt = r_asm;
    if (w_rd_state && (r_cnt != 3'd0)) begin
      w_asm_nxt[{w_lane, 3'b000} +: 8] = ram_din;
    end
  end

  // IF completion is suppressed when flush arrives in the final cycle too.
  assign w_if_fin  = (r_state == ST_IF_RD) & ~flush & w_last_rd;
  assign w_mem_fin = ((r_state == ST_MEM_RD) & w_last_rd) |
                     ((r_state == ST_MEM_WR) & w_last_wr);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and RAM-side outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    ram_a       = '0;
    ram_dout    = 8'h00;
    ram_wr      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_grant_mem) begin
          w_state_nxt = mem_we ? ST_MEM_WR : ST_MEM_RD;
        end else if (w_grant_if) begin
          w_state_nxt = ST_IF_RD;
        end
      end
      ST_IF_RD: begin
        if (w_in_range) begin
          ram_a = w_addr;
        end
        if (flush || w_last_rd) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MEM_RD: begin
        if (w_in_range) begin
          ram_a = w_addr;
        end
        if (w_last_rd) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MEM_WR: begin
        if (w_in_range) begin
          ram_a    = w_addr;
          ram_dout = w_wr_byte;
          ram_wr   = 1'b1;
        end
        if (w_last_wr) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: access parameters, byte counter, assembly and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_base      <= '0;
      r_cnt       <= 3'd0;
      r_n         <= 3'd0;
      r_wdata     <= 32'h0;
      r_asm       <= 32'h0;
      r_if_data   <= 32'h0;
      r_mem_rdata <= 32'h0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
    end else begin
      r_if_done  <= w_if_fin;
      r_mem_done <= w_mem_fin;

      if (w_grant_mem) begin
        r_base  <= mem_addr;
        r_n     <= len_to_n(mem_len);
        r_wdata <= mem_wdata;
        r_cnt   <= 3'd0;
        r_asm   <= 32'h0;
      end else if (w_grant_if) begin
        r_base  <= if_addr;
        r_n     <= 3'd4;
        r_wdata <= 32'h0;
        r_cnt   <= 3'd0;
        r_asm   <= 32'h0;
      end else if (r_state != ST_IDLE) begin
        r_cnt <= (w_state_nxt == ST_IDLE) ? 3'd0 : (r_cnt + 3'd1);
        r_asm <= w_asm_nxt;
      end

      if (w_if_fin) begin
        r_if_data <= w_asm_nxt;
      end
      if ((r_state == ST_MEM_RD) && w_last_rd) begin
        r_mem_rdata <= w_asm_nxt;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline-side outputs
  // --------------------------------------------------------------------------
  assign if_done      = r_if_done;
  assign if_data      = r_if_data;
  assign mem_done     = r_mem_done;
  assign mem_rdata    = r_mem_rdata;
  assign stallreq_if  = if_req & ~r_if_done;
  assign stallreq_mem = mem_req & ~r_mem_done;

endmodule : mem_ctrl
`default_nettype wire
